// File: rtl/nmux_arbiter.sv
// Round-robin arbiter driving the select of a shared N_REQ-input mux, with per-grant bursts
// bounded by a tagged last beat or MAX_BURST transfers.
module nmux_arbiter #(
   parameter int unsigned N_REQ     = 5,
   parameter int unsigned SEL_W     = 3,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_enable,
   input  logic [N_REQ-1:0] io_req_valid,
   input  logic [N_REQ-1:0] io_req_last,
   input  logic             io_out_ready,
   output logic [SEL_W-1:0] io_sel,
   output logic [N_REQ-1:0] io_grant,
   output logic [N_REQ-1:0] io_req_ready,
   output logic             io_out_valid,
   output logic             io_out_last,
   output logic             io_busy
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [3:0]       LastBeat = 4'(MAX_BURST - 1);
   localparam logic [N_REQ-1:0] GrantOne = N_REQ'(1);
   localparam logic [SEL_W:0]   NReqExt  = (SEL_W + 1)'(N_REQ);

   state_e           state_q;
   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] sel_q;
   logic [3:0]       beats_q;
   logic [N_REQ-1:0] grant_q;

   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic [SEL_W:0]   cand;
   logic [SEL_W-1:0] ptr_next;
   logic             xfer;

   // Scan from ptr_q upward with wrap; first valid requester wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr_q} + (SEL_W + 1)'(i);
         if (cand >= NReqExt) cand = cand - NReqExt;
         if (!pick_found && io_req_valid[cand[SEL_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[SEL_W-1:0];
         end
      end
   end

   assign ptr_next     = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
   assign io_busy      = (state_q == StGrant);
   assign io_sel       = sel_q;
   assign io_grant     = grant_q;
   assign io_req_ready = grant_q & {N_REQ{io_out_ready}};
   assign io_out_valid = io_busy & io_req_valid[sel_q];
   assign io_out_last  = io_out_valid & (io_req_last[sel_q] | (beats_q == LastBeat));
   assign xfer         = io_out_valid & io_out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         sel_q   <= '0;
         beats_q <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (io_enable && pick_found) begin
                  sel_q   <= pick_idx;
                  grant_q <= GrantOne << pick_idx;
                  beats_q <= '0;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               // The grant is held while the owner stalls; only its last beat releases it.
               if (xfer) begin
                  if (io_out_last) begin
                     ptr_q   <= ptr_next;
                     grant_q <= '0;
                     beats_q <= '0;
                     state_q <= StIdle;
                  end else begin
                     beats_q <= beats_q + 4'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nmux_arbiter.sv
// Directed bench for nmux_arbiter: reset, single beat, fairness, burst limit, stalls,
// enable gating and asynchronous reset mid-burst.
module tb_nmux_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       io_enable = 1'b1;
   logic [4:0] io_req_valid = '0;
   logic [4:0] io_req_last = '0;
   logic       io_out_ready = 1'b1;
   logic [2:0] io_sel;
   logic [4:0] io_grant;
   logic [4:0] io_req_ready;
   logic       io_out_valid;
   logic       io_out_last;
   logic       io_busy;

   int checks = 0;
   int failures = 0;

   nmux_arbiter #(.N_REQ(5), .SEL_W(3), .MAX_BURST(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_enable    (io_enable),
      .io_req_valid (io_req_valid),
      .io_req_last  (io_req_last),
      .io_out_ready (io_out_ready),
      .io_sel       (io_sel),
      .io_grant     (io_grant),
      .io_req_ready (io_req_ready),
      .io_out_valid (io_out_valid),
      .io_out_last  (io_out_last),
      .io_busy      (io_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] sel, input logic [4:0] grant,
                          input logic [4:0] rdy, input logic ov, input logic ol,
                          input logic busy);
      chk($sformatf("%s.sel", tag), 32'(io_sel), 32'(sel));
      chk($sformatf("%s.grant", tag), 32'(io_grant), 32'(grant));
      chk($sformatf("%s.req_ready", tag), 32'(io_req_ready), 32'(rdy));
      chk($sformatf("%s.out_valid", tag), 32'(io_out_valid), 32'(ov));
      chk($sformatf("%s.out_last", tag), 32'(io_out_last), 32'(ol));
      chk($sformatf("%s.busy", tag), 32'(io_busy), 32'(busy));
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int order [6];
      order = '{0, 1, 2, 3, 4, 0};

      // Reset state
      #2;
      chk_out("rst", 3'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
      chk("rst.ptr", 32'(dut.ptr_q), 32'd0);
      chk("rst.beats", 32'(dut.beats_q), 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // Single requester, single beat
      io_req_valid = 5'b00100;
      io_req_last  = 5'b00100;
      #1;
      chk_out("single.idle", 3'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
      tick();
      #1;
      chk_out("single.grant", 3'd2, 5'b00100, 5'b00100, 1'b1, 1'b1, 1'b1);
      tick();
      io_req_valid = '0;
      io_req_last  = '0;
      #1;
      chk_out("single.after", 3'd2, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
      chk("single.ptr", 32'(dut.ptr_q), 32'd3);

      // Reset again so fairness starts from ptr 0
      reset = 1'b0;
      #1;
      chk("rr.rst.ptr", 32'(dut.ptr_q), 32'd0);
      reset = 1'b1;

      // Round-robin fairness: one bubble between single-beat grants
      io_req_valid = 5'b11111;
      io_req_last  = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d.bubble", k), 32'(io_busy), 32'd0);
         tick();
         #1;
         chk_out($sformatf("rr%0d", k), 3'(order[k]), 5'(1 << order[k]),
                 5'(1 << order[k]), 1'b1, 1'b1, 1'b1);
         tick();
      end
      io_req_valid = '0;
      io_req_last  = '0;
      #1;
      chk("rr.ptr", 32'(dut.ptr_q), 32'd1);

      // Burst limit: requester 1 streams with last=0, released on beat 4
      io_req_valid = 5'b00010;
      tick();
      for (int b = 0; b < 4; b++) begin
         #1;
         chk_out($sformatf("burst.b%0d", b), 3'd1, 5'b00010, 5'b00010, 1'b1, (b == 3), 1'b1);
         tick();
      end
      io_req_valid = 5'b10010;
      io_req_last  = 5'b10000;
      #1;
      chk("burst.release.busy", 32'(io_busy), 32'd0);
      chk("burst.release.ptr", 32'(dut.ptr_q), 32'd2);
      tick();
      #1;
      chk_out("burst.other", 3'd4, 5'b10000, 5'b10000, 1'b1, 1'b1, 1'b1);
      tick();
      tick();
      io_req_last = 5'b00010;
      #1;
      chk_out("burst.regrant", 3'd1, 5'b00010, 5'b00010, 1'b1, 1'b1, 1'b1);
      tick();
      io_req_valid = '0;
      io_req_last  = '0;
      #1;
      chk("burst.done.ptr", 32'(dut.ptr_q), 32'd2);

      // Backpressure and valid gaps on requester 3
      io_req_valid = 5'b01000;
      tick();
      io_out_ready = 1'b0;
      #1;
      chk_out("bp.stall", 3'd3, 5'b01000, 5'b00000, 1'b1, 1'b0, 1'b1);
      tick();
      io_out_ready = 1'b1;
      #1;
      chk("bp.xfer1.beats", 32'(dut.beats_q), 32'd0);
      tick();
      io_req_valid = '0;
      #1;
      chk_out("bp.gap1", 3'd3, 5'b01000, 5'b01000, 1'b0, 1'b0, 1'b1);
      tick();
      #1;
      chk_out("bp.gap2", 3'd3, 5'b01000, 5'b01000, 1'b0, 1'b0, 1'b1);
      tick();
      io_req_valid = 5'b01000;
      io_out_ready = 1'b0;
      #1;
      chk("bp.hold.beats", 32'(dut.beats_q), 32'd1);
      tick();
      io_out_ready = 1'b1;
      #1;
      chk("bp.xfer2.last", 32'(io_out_last), 32'd0);
      tick();
      #1;
      chk("bp.xfer3.beats", 32'(dut.beats_q), 32'd2);
      chk("bp.xfer3.last", 32'(io_out_last), 32'd0);
      tick();
      #1;
      chk("bp.xfer4.beats", 32'(dut.beats_q), 32'd3);
      chk_out("bp.xfer4", 3'd3, 5'b01000, 5'b01000, 1'b1, 1'b1, 1'b1);
      tick();
      io_req_valid = '0;
      #1;
      chk("bp.done.busy", 32'(io_busy), 32'd0);
      chk("bp.done.ptr", 32'(dut.ptr_q), 32'd4);

      // Enable dropped mid-burst: burst completes, no new grant while disabled
      io_req_valid = 5'b00001;
      tick();
      io_enable = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk_out($sformatf("en.b%0d", b), 3'd0, 5'b00001, 5'b00001, 1'b1, (b == 3), 1'b1);
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("en.off%0d.grant", c), 32'(io_grant), 32'd0);
         chk($sformatf("en.off%0d.busy", c), 32'(io_busy), 32'd0);
         tick();
      end
      chk("en.ptr", 32'(dut.ptr_q), 32'd1);
      io_enable = 1'b1;
      tick();
      #1;
      chk_out("en.regrant", 3'd0, 5'b00001, 5'b00001, 1'b1, 1'b0, 1'b1);
      tick();

      // Asynchronous reset mid-burst on the second burst
      reset = 1'b0;
      #1;
      chk_out("arst", 3'd0, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
      chk("arst.ptr", 32'(dut.ptr_q), 32'd0);
      chk("arst.beats", 32'(dut.beats_q), 32'd0);
      tick();
      #1;
      chk("arst.held.busy", 32'(io_busy), 32'd0);
      reset = 1'b1;
      tick();
      #1;
      chk_out("arst.regrant", 3'd0, 5'b00001, 5'b00001, 1'b1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nmux_arbiter.md
# nmux_arbiter

Round-robin arbiter that shares the 5-input, 16-bit `nMux` datapath among five requesters. It drives the mux select, grants one requester at a time and holds the grant for a burst. A burst ends on a tagged last beat or at a beat limit. The arbiter sits beside the mux: the mux output is the data channel, and this block generates the valid/ready control around it.

## Interface
Parameters:
- `N_REQ`, 5: number of requesters; equals the mux input count.
- `SEL_W`, 3: select width, ceil(log2(N_REQ)).
- `MAX_BURST`, 4: maximum beats per grant, range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_enable`  in  1  1 = new grants allowed; 0 = no new grant, a current burst still completes.
- `io_req_valid`  in  5  bit i = requester i has a beat on `io_Dvect_i`.
- `io_req_last`  in  5  bit i = requester i's current beat is the last of its packet.
- `io_out_ready`  in  1  downstream accepts the mux output.
- `io_sel`  out  3  drives `nMux` select; values 0..4 only.
- `io_grant`  out  5  one-hot owner of the datapath; all zeros when idle.
- `io_req_ready`  out  5  bit i = `io_grant[i]` & `io_out_ready`.
- `io_out_valid`  out  1  mux output is valid this cycle.
- `io_out_last`  out  1  current output beat is the last of the burst.
- `io_busy`  out  1  1 while in GRANT.

## Operation
- FSM has two states, IDLE and GRANT, plus registers `ptr[2:0]` (round-robin start), `sel_r[2:0]` and `beats[3:0]`.
- IDLE behaviour:
  - If `io_enable` = 1 and any `io_req_valid` bit is set, pick the first set bit scanning from `ptr` upward with wrap 4→0.
  - Load `sel_r` with that index, clear `beats` and move to GRANT.
  - Otherwise stay in IDLE with `sel_r` unchanged.
- GRANT behaviour:
  - `io_grant` = onehot(`sel_r`).
  - `io_out_valid` = `io_req_valid[sel_r]`.
  - A transfer is `io_out_valid` & `io_out_ready`; each transfer increments `beats`.
- `io_out_last` = `io_out_valid` & (`io_req_last[sel_r]` | (`beats` == `MAX_BURST`-1)).
- Release condition: a transfer with `io_out_last` = 1. On release:
  - `ptr` ← `sel_r`+1 mod 5 (4 wraps to 0).
  - State ← IDLE.
- If the owner drops valid mid-burst, the grant is held and no timeout applies. The owner must complete its packet.
- `io_enable` is sampled only in IDLE. Deasserting it during GRANT does not truncate the burst.
- `io_sel` = `sel_r` at all times, including IDLE, so the mux select never glitches between bursts.
- Reset value of every output (state IDLE):
  - `io_sel` = 0, `io_grant` = 0, `io_req_ready` = 0.
  - `io_out_valid` = 0, `io_out_last` = 0, `io_busy` = 0.
  - Internal: `ptr` = 0, `beats` = 0.
- Reset asserted mid-burst: outputs return to the reset values immediately (asynchronously). The partial packet is abandoned, and the requester sees ready fall.

## Timing
- Arbitration latency: a request seen in an IDLE cycle produces `io_grant` and `io_busy` on the next cycle.
- The earliest transfer happens in that same next cycle.
- Release-to-regrant gap is exactly one IDLE cycle. A back-to-back burst costs one bubble.
- `io_req_ready`, `io_out_valid` and `io_out_last` are combinational from `io_out_ready`, `io_req_valid` and `io_req_last` and the registered state.
- `io_sel` and `io_grant` are purely registered.
- Simultaneous requests resolve by round-robin from `ptr` only; no fixed priority applies.
- A requester that asserts valid during another's burst waits at most 4 bursts plus 4 bubbles.

## Test plan
- Single requester, single beat:
  - Stimulus: after reset, set `io_req_valid` = 00100 with last = 1 and out_ready = 1.
  - Required response: cycle 1 `io_sel` = 2 and `io_grant` = 00100; one transfer with `io_out_last` = 1; cycle 2 IDLE; `ptr` = 3.
- Round-robin fairness:
  - Stimulus: all five valid, each sending a 1-beat packet, ready held 1.
  - Required response: grant order 0,1,2,3,4,0 with one idle cycle between grants.
- Burst limit:
  - Stimulus: requester 1 streams 10 beats with last = 0 and `MAX_BURST` = 4.
  - Required response: `io_out_last` = 1 on beat 4; release; requester 1 is regranted only after the others are scanned.
- Backpressure and gaps:
  - Stimulus: during requester 3's grant, toggle out_ready and drop valid for 2 cycles.
  - Required response: `beats` counts only transfers; the grant is held; `io_sel` stays 3.
- Enable and reset:
  - Stimulus: deassert `io_enable` mid-burst, then assert `reset` mid-burst on a second burst.
  - Required response: the first burst completes and no new grant is issued while disabled; on reset, all outputs are 0 and `ptr` = 0 in the same cycle.
